// File: rtl/mp_window_fetch.sv
// Max-pool 2x2 window fetcher: walks NUM_BANK row-buffer FIFO banks, alternating even/odd FIFOs, into a credit-guarded output buffer.
// Optional sideband (mp_col_last, mp_bank) is compiled in with `define MP_SIDEBAND_EN.
module mp_window_fetch #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned NUM_BANK   = 2,
    parameter int unsigned CNT_W      = 9,
    parameter int unsigned OBUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CNT_W-1:0]             ifm_width,
    input  logic [NUM_BANK-1:0]          ev_up_avail,
    input  logic [NUM_BANK-1:0]          ev_dn_avail,
    input  logic [NUM_BANK-1:0]          od_up_avail,
    input  logic [NUM_BANK-1:0]          od_dn_avail,
    output logic [NUM_BANK-1:0]          ev_rd,
    output logic [NUM_BANK-1:0]          od_rd,
    input  logic [NUM_BANK*2*DATA_W-1:0] ev_up_data,
    input  logic [NUM_BANK*2*DATA_W-1:0] ev_dn_data,
    input  logic [NUM_BANK*2*DATA_W-1:0] od_up_data,
    input  logic [NUM_BANK*2*DATA_W-1:0] od_dn_data,
    output logic                         mp_valid,
    input  logic                         mp_ready,
    output logic [4*DATA_W-1:0]          mp_data
`ifdef MP_SIDEBAND_EN
    ,
    output logic                         mp_col_last,
    output logic [$clog2(NUM_BANK)-1:0]  mp_bank
`endif
);

    localparam int unsigned BANK_W = $clog2(NUM_BANK);
    localparam int unsigned PTR_W  = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int unsigned OCC_W  = $clog2(OBUF_DEPTH + 1);
    localparam int unsigned WORD_W = 2 * DATA_W;
    localparam int unsigned ENT_W  = 4 * DATA_W;

    logic [BANK_W-1:0] bank_q, bank_d;
    logic [CNT_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  wpr_q, wpr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              infl_q, infl_d;
    logic              infl_par_q, infl_par_d;
    logic [BANK_W-1:0] infl_bank_q, infl_bank_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ENT_W-1:0]  data_q [OBUF_DEPTH];
    logic [ENT_W-1:0]  data_d [OBUF_DEPTH];
`ifdef MP_SIDEBAND_EN
    logic              infl_last_q, infl_last_d;
    logic              last_q [OBUF_DEPTH];
    logic              last_d [OBUF_DEPTH];
    logic [BANK_W-1:0] btag_q [OBUF_DEPTH];
    logic [BANK_W-1:0] btag_d [OBUF_DEPTH];
`endif

    logic              sel_pair;
    logic              pop;
    logic              credit_ok;
    logic              issue;
    logic              win_last;
    logic [WORD_W-1:0] up_word;
    logic [WORD_W-1:0] dn_word;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign mp_valid = (occ_q != '0);
    assign mp_data  = data_q[rd_ptr_q];
`ifdef MP_SIDEBAND_EN
    assign mp_col_last = last_q[rd_ptr_q];
    assign mp_bank     = btag_q[rd_ptr_q];
`endif

    always_comb begin
        sel_pair  = win_q[0] ? (od_up_avail[bank_q] & od_dn_avail[bank_q])
                             : (ev_up_avail[bank_q] & ev_dn_avail[bank_q]);
        pop       = mp_valid & mp_ready;
        // Credits cover buffered entries plus the read whose data lands next cycle.
        credit_ok = (32'(occ_q) + 32'(infl_q)) < (OBUF_DEPTH + 32'(pop));
        issue     = !rst && sel_pair && credit_ok;
        win_last  = (win_q == wpr_q - 1'b1);

        ev_rd = '0;
        od_rd = '0;
        if (issue) begin
            if (win_q[0]) od_rd[bank_q] = 1'b1;
            else          ev_rd[bank_q] = 1'b1;
        end

        bank_d = bank_q;
        win_d  = win_q;
        wpr_d  = wpr_q;
        if (issue) begin
            if (win_last) begin
                win_d  = '0;
                wpr_d  = ifm_width >> 1;
                bank_d = (bank_q == BANK_W'(NUM_BANK - 1)) ? '0 : bank_q + 1'b1;
            end else begin
                win_d = win_q + 1'b1;
            end
        end

        infl_d      = issue;
        infl_par_d  = win_q[0];
        infl_bank_d = bank_q;

        up_word = infl_par_q ? od_up_data[infl_bank_q*WORD_W +: WORD_W]
                             : ev_up_data[infl_bank_q*WORD_W +: WORD_W];
        dn_word = infl_par_q ? od_dn_data[infl_bank_q*WORD_W +: WORD_W]
                             : ev_dn_data[infl_bank_q*WORD_W +: WORD_W];

        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
`ifdef MP_SIDEBAND_EN
        infl_last_d = win_last;
        last_d      = last_q;
        btag_d      = btag_q;
`endif
        if (infl_q) begin
            data_d[wr_ptr_q] = {dn_word, up_word};
`ifdef MP_SIDEBAND_EN
            last_d[wr_ptr_q] = infl_last_q;
            btag_d[wr_ptr_q] = infl_bank_q;
`endif
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

        occ_d = occ_q + OCC_W'(infl_q) - OCC_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q      <= '0;
            win_q       <= '0;
            wpr_q       <= ifm_width >> 1;
            occ_q       <= '0;
            infl_q      <= 1'b0;
            infl_par_q  <= 1'b0;
            infl_bank_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
                data_q[i] <= '0;
`ifdef MP_SIDEBAND_EN
                last_q[i] <= 1'b0;
                btag_q[i] <= '0;
`endif
            end
`ifdef MP_SIDEBAND_EN
            infl_last_q <= 1'b0;
`endif
        end else begin
            bank_q      <= bank_d;
            win_q       <= win_d;
            wpr_q       <= wpr_d;
            occ_q       <= occ_d;
            infl_q      <= infl_d;
            infl_par_q  <= infl_par_d;
            infl_bank_q <= infl_bank_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            data_q      <= data_d;
`ifdef MP_SIDEBAND_EN
            infl_last_q <= infl_last_d;
            last_q      <= last_d;
            btag_q      <= btag_d;
`endif
        end
    end

endmodule

// File: tb/tb_mp_window_fetch.sv
// Bench for mp_window_fetch: FIFO source model, reference sequencer and scoreboard of expected windows.
module tb_mp_window_fetch;

    localparam int DW    = 16;
    localparam int NB    = 2;
    localparam int CW    = 9;
    localparam int DEPTH = 2;
    localparam int WW    = 2 * DW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CW-1:0]     ifm_width;
    logic [NB-1:0]     ev_up_avail, ev_dn_avail, od_up_avail, od_dn_avail;
    logic [NB-1:0]     ev_rd, od_rd;
    logic [NB*WW-1:0]  ev_up_data, ev_dn_data, od_up_data, od_dn_data;
    logic              mp_valid;
    logic              mp_ready;
    logic [4*DW-1:0]   mp_data;
`ifdef MP_SIDEBAND_EN
    logic              mp_col_last;
    logic [$clog2(NB)-1:0] mp_bank;
`endif

    always #5 clk = ~clk;

    mp_window_fetch #(
        .DATA_W(DW), .NUM_BANK(NB), .CNT_W(CW), .OBUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .ifm_width(ifm_width),
        .ev_up_avail(ev_up_avail), .ev_dn_avail(ev_dn_avail),
        .od_up_avail(od_up_avail), .od_dn_avail(od_dn_avail),
        .ev_rd(ev_rd), .od_rd(od_rd),
        .ev_up_data(ev_up_data), .ev_dn_data(ev_dn_data),
        .od_up_data(od_up_data), .od_dn_data(od_dn_data),
        .mp_valid(mp_valid), .mp_ready(mp_ready), .mp_data(mp_data)
`ifdef MP_SIDEBAND_EN
        , .mp_col_last(mp_col_last), .mp_bank(mp_bank)
`endif
    );

    typedef struct {
        logic [63:0] data;
        int          cyc;
        logic        last;
        int          bank;
    } exp_t;

    typedef struct {
        int width;
        int steps;
        int ev0, od0, ev1, od1;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[4];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   m_bank, m_win, m_wpr;
    int   ev_cnt[NB], od_cnt[NB];
    int   t_ev[NB], t_od[NB];
    int   snap;

    function automatic logic [31:0] word(int b, int par, int dn, int k);
        return 32'((b << 28) | (par << 27) | (dn << 26) | ((k & 16'hFFFF) << 8) | (par * 2 + dn + 1));
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: check outputs against the reference at negedge, then serve FIFO pops after the edge.
    task automatic step();
        logic [NB-1:0] ev_s, od_s, exp_ev, exp_od;
        bit   exp_valid, pop, iss, av;
        int   par;
        exp_t e;
        @(negedge clk);
        ev_s   = ev_rd;
        od_s   = od_rd;
        exp_ev = '0;
        exp_od = '0;
        if (rst) begin
            sb.delete();
            m_bank = 0;
            m_win  = 0;
            m_wpr  = int'(ifm_width >> 1);
            for (int b = 0; b < NB; b++) begin
                t_ev[b] = 0;
                t_od[b] = 0;
            end
        end else begin
            exp_valid = (sb.size() != 0) && (sb[0].cyc + 2 <= cyc);
            chk("mp_valid", 64'(mp_valid), 64'(exp_valid));
            if (exp_valid) begin
                chk("mp_data", mp_data, sb[0].data);
`ifdef MP_SIDEBAND_EN
                chk("mp_col_last", 64'(mp_col_last), 64'(sb[0].last));
                chk("mp_bank", 64'(mp_bank), 64'(sb[0].bank));
`endif
            end
            pop = exp_valid && mp_ready;
            par = m_win % 2;
            av  = (par != 0) ? (od_up_avail[m_bank] && od_dn_avail[m_bank])
                             : (ev_up_avail[m_bank] && ev_dn_avail[m_bank]);
            iss = av && ((sb.size() - int'(pop)) < DEPTH);
            if (pop) void'(sb.pop_front());
            if (iss) begin
                if (par != 0) begin
                    exp_od[m_bank] = 1'b1;
                    e.data = {word(m_bank, 1, 1, od_cnt[m_bank]), word(m_bank, 1, 0, od_cnt[m_bank])};
                end else begin
                    exp_ev[m_bank] = 1'b1;
                    e.data = {word(m_bank, 0, 1, ev_cnt[m_bank]), word(m_bank, 0, 0, ev_cnt[m_bank])};
                end
                e.cyc  = cyc;
                e.last = (m_win == m_wpr - 1);
                e.bank = m_bank;
                sb.push_back(e);
                if (m_win == m_wpr - 1) begin
                    m_win  = 0;
                    m_bank = (m_bank + 1) % NB;
                    m_wpr  = int'(ifm_width >> 1);
                end else begin
                    m_win++;
                end
            end
        end
        chk("ev_rd", 64'(ev_s), 64'(exp_ev));
        chk("od_rd", 64'(od_s), 64'(exp_od));
        for (int b = 0; b < NB; b++) begin
            t_ev[b] += int'(ev_s[b]);
            t_od[b] += int'(od_s[b]);
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int b = 0; b < NB; b++) begin
            if (ev_s[b]) begin
                ev_up_data[b*WW +: WW] = word(b, 0, 0, ev_cnt[b]);
                ev_dn_data[b*WW +: WW] = word(b, 0, 1, ev_cnt[b]);
                ev_cnt[b]++;
            end
            if (od_s[b]) begin
                od_up_data[b*WW +: WW] = word(b, 1, 0, od_cnt[b]);
                od_dn_data[b*WW +: WW] = word(b, 1, 1, od_cnt[b]);
                od_cnt[b]++;
            end
        end
    endtask

    task automatic do_reset(int w);
        rst       = 1'b1;
        ifm_width = CW'(w);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{width: 26, steps: 26, ev0: 7,  od0: 6,  ev1: 7,  od1: 6};
        vecs[1] = '{width: 52, steps: 60, ev0: 17, od0: 17, ev1: 13, od1: 13};
        vecs[2] = '{width: 2,  steps: 10, ev0: 5,  od0: 0,  ev1: 5,  od1: 0};
        vecs[3] = '{width: 6,  steps: 10, ev0: 4,  od0: 2,  ev1: 3,  od1: 1};

        ifm_width   = CW'(26);
        ev_up_avail = '1; ev_dn_avail = '1;
        od_up_avail = '1; od_dn_avail = '1;
        ev_up_data  = '0; ev_dn_data  = '0;
        od_up_data  = '0; od_dn_data  = '0;
        mp_ready    = 1'b1;
        for (int b = 0; b < NB; b++) begin
            ev_cnt[b] = 0;
            od_cnt[b] = 0;
        end

        // Free-running rows: strobe tallies per bank/parity
        for (int i = 0; i < 4; i++) begin
            do_reset(vecs[i].width);
            repeat (vecs[i].steps) step();
            chk("tally_ev0", 64'(t_ev[0]), 64'(vecs[i].ev0));
            chk("tally_od0", 64'(t_od[0]), 64'(vecs[i].od0));
            chk("tally_ev1", 64'(t_ev[1]), 64'(vecs[i].ev1));
            chk("tally_od1", 64'(t_od[1]), 64'(vecs[i].od1));
        end

        // Width change mid-row takes effect only at the next row
        do_reset(26);
        repeat (5) step();
        ifm_width = CW'(52);
        repeat (8) step();
        chk("wchg_bank0_row0", 64'(t_ev[0] + t_od[0]), 64'(13));
        chk("wchg_bank1_row0", 64'(t_ev[1] + t_od[1]), 64'(0));
        repeat (26) step();
        chk("wchg_bank1_row1", 64'(t_ev[1] + t_od[1]), 64'(26));
        step();
        chk("wchg_bank0_row2", 64'(t_ev[0] + t_od[0]), 64'(14));

        // Backpressure: buffer fills, strobes stop, order preserved on release
        do_reset(26);
        repeat (4) step();
        mp_ready = 1'b0;
        snap = t_ev[0] + t_od[0] + t_ev[1] + t_od[1];
        repeat (10) step();
        chk("stall_strobes", 64'(t_ev[0] + t_od[0] + t_ev[1] + t_od[1] - snap), 64'(0));
        chk("stall_buffered", 64'(sb.size()), 64'(DEPTH));
        mp_ready = 1'b1;
        repeat (20) step();

        // Odd down-row FIFO empty blocks the odd window without touching even
        do_reset(26);
        od_dn_avail[0] = 1'b0;
        repeat (6) step();
        chk("block_ev0", 64'(t_ev[0]), 64'(1));
        chk("block_od0", 64'(t_od[0]), 64'(0));
        od_dn_avail[0] = 1'b1;
        step();
        chk("resume_od0", 64'(t_od[0]), 64'(1));
        repeat (5) step();

        // Reset with windows buffered and one read in flight
        do_reset(26);
        step();
        mp_ready = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_valid", 64'(mp_valid), 64'(0));
        chk("rst_data", mp_data, 64'(0));
        mp_ready = 1'b1;
        repeat (8) step();
        chk("rst_restart_bank0", 64'(t_ev[0] + t_od[0]), 64'(8));

        // Randomised availability, backpressure and row widths
        do_reset(6);
        repeat (400) begin
            for (int b = 0; b < NB; b++) begin
                ev_up_avail[b] = ($urandom_range(0, 3) != 0);
                ev_dn_avail[b] = ($urandom_range(0, 3) != 0);
                od_up_avail[b] = ($urandom_range(0, 3) != 0);
                od_dn_avail[b] = ($urandom_range(0, 3) != 0);
            end
            mp_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) ifm_width = CW'(2 * $urandom_range(1, 5));
            step();
        end
        ev_up_avail = '0; ev_dn_avail = '0;
        od_up_avail = '0; od_dn_avail = '0;
        mp_ready = 1'b1;
        repeat (6) step();
        chk("drain_empty", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
